// File: rtl/addr_signed_dmr_serial.sv
// Digit-serial signed adder with duplicated digit adders.
// A copy mismatch re-executes the digit; too many consecutive retries abort.
module addr_signed_dmr_serial #(
  parameter int W = 8,
  parameter int D = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_fault_inj,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W:0]   o_sum,
  output logic         o_err,
  output logic [7:0]   o_retries
);

  localparam int N  = W / D;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           sa;
  logic           sb;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [3:0]     dretry;
  logic [W-1:0]   acc;

  logic [D:0]     ra;
  logic [D:0]     rb;
  logic           agree;
  logic           last;
  logic [W+D-1:0] nxt;

  always_comb begin
    ra = {1'b0, a_r[D-1:0]} + {1'b0, b_r[D-1:0]}
       + {{D{1'b0}}, carry};
    rb = {1'b0, a_r[D-1:0]} + {1'b0, b_r[D-1:0]}
       + {{D{1'b0}}, carry};
    rb[0] = rb[0] ^ i_fault_inj;
    agree = (ra == rb);
    last  = (idx == IW'(N - 1));
    // committed digit enters at the top; after N shifts acc is aligned
    nxt   = {ra[D-1:0], acc};
  end

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      dretry    <= '0;
      acc       <= '0;
      o_sum     <= '0;
      o_err     <= 1'b0;
      o_retries <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            a_r       <= i_a;
            b_r       <= i_b;
            sa        <= i_a[W-1];
            sb        <= i_b[W-1];
            carry     <= 1'b0;
            idx       <= '0;
            dretry    <= '0;
            acc       <= '0;
            o_err     <= 1'b0;
            o_retries <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (agree) begin
            a_r    <= a_r >> D;
            b_r    <= b_r >> D;
            carry  <= ra[D];
            acc    <= nxt[W+D-1:D];
            idx    <= idx + 1'b1;
            dretry <= '0;
            if (last) begin
              o_sum <= {sa ^ sb ^ ra[D], nxt[W+D-1:D]};
              o_err <= 1'b0;
              state <= DONE;
            end
          end else begin
            if (o_retries != 8'hFF)
              o_retries <= o_retries + 8'd1;
            if (dretry == 4'(MAX_RETRY)) begin
              o_sum <= '0;
              o_err <= 1'b1;
              state <= DONE;
            end else begin
              dretry <= dretry + 4'd1;
            end
          end
        end
        DONE: begin
          if (o_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_signed_dmr_serial.sv
// Directed and random checks of addr_signed_dmr_serial
// against a per-cycle digit/retry outcome model.
module tb_addr_signed_dmr_serial;

  localparam int W = 8;
  localparam int D = 2;
  localparam int MR = 3;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_fault_inj = 1'b0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W:0]   o_sum;
  logic         o_err;
  logic [7:0]   o_retries;

  int n_chk = 0;
  int n_fail = 0;

  addr_signed_dmr_serial #(.W(W), .D(D), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b),
    .i_fault_inj(i_fault_inj),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_sum(o_sum), .o_err(o_err),
    .o_retries(o_retries)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic [31:0] fmask,
                    input int hold);
    int lat, elat, cons, dig, eret, cyc;
    logic eerr;
    logic [W:0] esum, held;
    elat = 0; cons = 0; dig = 0; eret = 0; eerr = 1'b0;
    for (int c = 0; c < 32; c++) begin
      elat++;
      if (fmask[c]) begin
        eret++;
        cons++;
        if (cons > MR) begin
          eerr = 1'b1;
          break;
        end
      end else begin
        dig++;
        cons = 0;
        if (dig == N) break;
      end
    end
    esum = eerr ? '0 : ({a[W-1], a} + {b[W-1], b});

    chk("idle_ready", i_ready, 1);
    i_a = a; i_b = b; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    cyc = 0;
    while (!o_valid && cyc < 40) begin
      i_a = W'($urandom);
      i_b = W'($urandom);
      i_fault_inj = fmask[cyc];
      step();
      cyc++;
    end
    i_fault_inj = 1'b0;
    lat = cyc;
    chk("latency", lat, elat);
    chk("valid", o_valid, 1);
    chk("sum", o_sum, esum);
    chk("err", o_err, eerr);
    chk("retries", o_retries, eret);
    held = o_sum;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", o_valid, 1);
      chk("hold_ready", i_ready, 0);
      chk("hold_sum", o_sum, held);
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk("ret_idle", i_ready, 1);
    chk("ret_valid", o_valid, 0);
    chk("keep_sum", o_sum, held);
    chk("keep_retries", o_retries, eret);
  endtask

  initial begin
    logic [31:0] m;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", i_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_retries", o_retries, 0);

    op(8'h7F, 8'h01, 32'h0, 0);
    op(8'h80, 8'h80, 32'h0, 0);
    op(8'hFF, 8'h01, 32'h0, 0);
    op(8'h35, 8'hC9, 32'h2, 0);
    op(8'h12, 8'h34, 32'hFFFF_FFFF, 0);
    op(8'h9A, 8'h7E, 32'h0, 3);

    i_a = 8'h55; i_b = 8'h66; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", i_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_sum", o_sum, 0);
    chk("midrst_err", o_err, 0);
    op(8'hC3, 8'hA5, 32'h0, 1);

    for (int t = 0; t < 25; t++) begin
      m = 0;
      for (int k = 0; k < 12; k++)
        if ($urandom_range(5) == 0) m[k] = 1'b1;
      if (t % 5 == 0) m[t % 4 +: 4] = 4'hF;
      op(W'($urandom), W'($urandom), m, $urandom_range(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
